// File: rtl/bus_timing_if.sv
// bus_timing_if -- signal bundle between the bus sequencer and its neighbours.
//
// Carries the SPI-bridge request/response handshake, the CPU control inputs
// and the shared RAM/IO bus drive and strobe outputs.
//   slave  : the sequencer (bus_timing) -- takes requests, drives bus/strobes
//   master : the SPI requester / top-level side
`timescale 1ns/1ps
interface bus_timing_if;
  // SPI-bridge handshake
  logic        spi_valid_i;
  logic        spi_we_i;
  logic [16:0] spi_addr_i;
  logic [7:0]  spi_wr_data_i;
  logic [7:0]  spi_rd_data_o;
  logic        spi_done_o;
  // CPU control and system bus
  logic        cpu_halt_i;
  logic        bus_rw_ni;
  logic [7:0]  bus_data_i;
  logic [16:0] bus_addr_o;
  logic        bus_addr_oe;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe;
  logic        bus_rw_no;
  logic        bus_rw_noe;
  logic        clk_cpu_o;
  logic        cpu_en_o;
  logic        cpu_ready_o;
  logic        ram_oe_no;
  logic        ram_we_no;

  modport slave (
    input  spi_valid_i, spi_we_i, spi_addr_i, spi_wr_data_i,
           cpu_halt_i, bus_rw_ni, bus_data_i,
    output spi_rd_data_o, spi_done_o,
           bus_addr_o, bus_addr_oe, bus_data_o, bus_data_oe,
           bus_rw_no, bus_rw_noe, clk_cpu_o, cpu_en_o, cpu_ready_o,
           ram_oe_no, ram_we_no
  );

  modport master (
    output spi_valid_i, spi_we_i, spi_addr_i, spi_wr_data_i,
           cpu_halt_i, bus_rw_ni, bus_data_i,
    input  spi_rd_data_o, spi_done_o,
           bus_addr_o, bus_addr_oe, bus_data_o, bus_data_oe,
           bus_rw_no, bus_rw_noe, clk_cpu_o, cpu_en_o, cpu_ready_o,
           ram_oe_no, ram_we_no
  );
endinterface

// File: rtl/bus_timing.sv
// bus_timing -- PET clone system bus sequencer.
//
// Splits clk_16_i into 16-cycle frames (1 MHz CPU phi0). Phases 0..7 (phi1)
// carry at most one SPI-bridge access; phases 8..15 (phi2) belong to the 6502.
// Every output is a flop: the combinational block computes what each output
// must be in the *next* phase and the flops present it for that whole cycle.
//
// Ports:
//   clk_16_i : 16 MHz system clock
//   reset_ni : asynchronous active-low reset
//   bus      : bus_timing_if.slave -- SPI handshake, CPU halt/R/W inputs,
//              bus address/data/R/W drive with enables, phi0, BE, RDY and
//              active-low RAM strobes
`timescale 1ns/1ps
module bus_timing (
  input  logic         clk_16_i,
  input  logic         reset_ni,
  bus_timing_if.slave  bus
);

  // What the current phi1 slot is doing; fixed for the whole frame once
  // granted at the phase 15 -> 0 edge.
  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_t;

  logic [3:0] phase;
  slot_t      slot_q;
  logic       cpu_rw_q;    // CPU R/W registered at the end of phase 8

  // Next-cycle view of state and outputs
  logic [3:0] phase_nxt;
  slot_t      slot_nxt;
  logic       cpu_rw_nxt;
  logic       clk_cpu_d, cpu_en_d, addr_oe_d, data_oe_d, rw_noe_d, rw_no_d;
  logic       ram_oe_nd, ram_we_nd, done_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    phase_nxt  = phase + 4'd1;
    slot_nxt   = slot_q;
    cpu_rw_nxt = cpu_rw_q;
    if (phase == 4'd15) begin
      if (!bus.spi_valid_i)  slot_nxt = SLOT_IDLE;
      else if (bus.spi_we_i) slot_nxt = SLOT_WRITE;
      else                   slot_nxt = SLOT_READ;
    end
    if (phase == 4'd8) cpu_rw_nxt = bus.bus_rw_ni;

    clk_cpu_d = phase_nxt[3];
    cpu_en_d  = 1'b1;
    addr_oe_d = 1'b0;
    data_oe_d = 1'b0;
    rw_noe_d  = 1'b0;
    rw_no_d   = 1'b1;
    ram_oe_nd = 1'b1;
    ram_we_nd = 1'b1;
    done_d    = 1'b0;

    if (phase_nxt[3]) begin
      // phi2: CPU owns the bus; only the RAM strobes are ours.
      ram_oe_nd = !(cpu_rw_nxt && (phase_nxt >= 4'd9));
      ram_we_nd = !(!cpu_rw_nxt && (phase_nxt inside {[4'd10:4'd14]}));
    end else if (slot_nxt != SLOT_IDLE) begin
      // SPI phi1: CPU tri-stated for all of 0..7; our drivers only in 1..6 so
      // phases 0 and 7 are dead time around the BE transitions.
      cpu_en_d  = 1'b0;
      addr_oe_d = phase_nxt inside {[4'd1:4'd6]};
      rw_noe_d  = addr_oe_d;
      rw_no_d   = !(addr_oe_d && (slot_nxt == SLOT_WRITE));
      if (slot_nxt == SLOT_WRITE) begin
        data_oe_d = phase_nxt inside {[4'd2:4'd5]};
        ram_we_nd = !(phase_nxt inside {[4'd3:4'd5]});
      end else begin
        ram_oe_nd = !(phase_nxt inside {[4'd2:4'd6]});
      end
      done_d = (phase_nxt == 4'd7);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase             <= 4'd0;
      slot_q            <= SLOT_IDLE;
      cpu_rw_q          <= 1'b1;
      bus.clk_cpu_o     <= 1'b0;
      bus.cpu_en_o      <= 1'b0;
      bus.cpu_ready_o   <= 1'b0;
      bus.ram_oe_no     <= 1'b1;
      bus.ram_we_no     <= 1'b1;
      bus.bus_addr_oe   <= 1'b0;
      bus.bus_data_oe   <= 1'b0;
      bus.bus_rw_noe    <= 1'b0;
      bus.bus_rw_no     <= 1'b1;
      bus.bus_addr_o    <= '0;
      bus.bus_data_o    <= '0;
      bus.spi_done_o    <= 1'b0;
      bus.spi_rd_data_o <= '0;
    end else begin
      phase    <= phase_nxt;
      slot_q   <= slot_nxt;
      cpu_rw_q <= cpu_rw_nxt;

      // Frame boundary: latch SPI attributes and the halt request. RDY can
      // therefore only move at 15 -> 0, never inside phi2.
      if (phase == 4'd15) begin
        bus.cpu_ready_o <= !bus.cpu_halt_i;
        if (bus.spi_valid_i) begin
          bus.bus_addr_o <= bus.spi_addr_i;
          bus.bus_data_o <= bus.spi_wr_data_i;
        end
      end

      // Read data is taken at the end of phase 5, one cycle before OE lifts.
      if (phase == 4'd5 && slot_q == SLOT_READ)
        bus.spi_rd_data_o <= bus.bus_data_i;

      bus.clk_cpu_o   <= clk_cpu_d;
      bus.cpu_en_o    <= cpu_en_d;
      bus.ram_oe_no   <= ram_oe_nd;
      bus.ram_we_no   <= ram_we_nd;
      bus.bus_addr_oe <= addr_oe_d;
      bus.bus_data_oe <= data_oe_d;
      bus.bus_rw_noe  <= rw_noe_d;
      bus.bus_rw_no   <= rw_no_d;
      bus.spi_done_o  <= done_d;
    end
  end

endmodule
